// File: rtl/resp_framer.sv
// resp_framer: serializes an ALU result (opcode + up to 8 bytes) into a 4-byte-header packet byte stream for UART TX
module resp_framer #(
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             opcode_i,
  input  logic [8*MAX_BYTES-1:0] result_i,
  input  logic [3:0]             nbytes_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [7:0]             data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o
);
  typedef enum logic [2:0] {IDLE, OPC, RSV, LEN_L, LEN_H, DATA} state_t;
  state_t state, state_nx;
  logic [3:0] idx, n_q, n_cl;
  logic [7:0] opc_q;
  logic [8*MAX_BYTES-1:0] res_q;
  logic cap, last;
  assign ready_o = state == IDLE;
  assign busy_o = !ready_o;
  assign valid_o = busy_o;
  assign cap = valid_i && ready_o;
  assign last = idx + 4'd1 == n_q;
  assign n_cl = nbytes_i > 4'd8 ? 4'd8 : nbytes_i;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:  state_nx = cap ? OPC : IDLE;
      OPC:   state_nx = ready_i ? RSV : OPC;
      RSV:   state_nx = ready_i ? LEN_L : RSV;
      LEN_L: state_nx = ready_i ? LEN_H : LEN_L;
      LEN_H: state_nx = ready_i ? (n_q != 4'd0 ? DATA : IDLE) : LEN_H;
      DATA:  state_nx = ready_i && last ? IDLE : DATA;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    data_o = 8'h00;
    case (state)
      OPC:   data_o = opc_q;
      LEN_L: data_o = 8'd4 + {4'd0, n_q};
      DATA:  data_o = res_q[{idx[2:0], 3'b000} +: 8];
      default: data_o = 8'h00;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= 4'd0;
      n_q   <= 4'd0;
      opc_q <= 8'h00;
      res_q <= '0;
    end else begin
      state <= state_nx;
      if (cap) begin
        opc_q <= opcode_i;
        res_q <= result_i;
        n_q   <= n_cl;
      end
      // index returns to 0 on frame exit so the next frame starts clean
      idx <= state == DATA && ready_i ? (last ? 4'd0 : idx + 4'd1) : idx;
    end
  end
endmodule

// File: tb/tb_resp_framer.sv
// tb_resp_framer: randomized self-checking bench for resp_framer against a byte-queue frame model
module tb_resp_framer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] opcode_i = 8'h00;
  logic [63:0] result_i = 64'h0;
  logic [3:0] nbytes_i = 4'd0;
  logic valid_i = 1'b0;
  logic ready_o;
  logic [7:0] data_o;
  logic valid_o;
  logic ready_i = 1'b0;
  logic busy_o;
  int n_chk = 0;
  int n_err = 0;

  resp_framer dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .result_i(result_i), .nbytes_i(nbytes_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0 repeating, 2 random ready
  // intrude: raise a competing request (~op, ~res, 3 bytes) from byte 2 onward
  // abort_at: byte position at which reset is pulsed (-1 for none)
  task automatic run_frame(input logic [7:0] op, input logic [63:0] res, input logic [3:0] nb,
                           input int mode, input bit intrude, input int abort_at);
    logic [7:0] exp[$];
    int n, i, cyc, stall;
    bit r;
    n = nb > 4'd8 ? 8 : int'(nb);
    exp.push_back(op);
    exp.push_back(8'h00);
    exp.push_back(8'(4 + n));
    exp.push_back(8'h00);
    for (int k = 0; k < n; k++) exp.push_back(res[8*k +: 8]);
    opcode_i = op;
    result_i = res;
    nbytes_i = nb;
    valid_i = 1'b1;
    ready_i = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    opcode_i = 8'($urandom);
    result_i = {$urandom, $urandom};
    nbytes_i = 4'($urandom);
    i = 0;
    cyc = 0;
    stall = 0;
    while (i < exp.size()) begin
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_valid", valid_o, 1'b0);
        check("abort_ready", ready_o, 1'b1);
        check("abort_data", data_o, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      check("valid", valid_o, 1'b1);
      check("busy", busy_o, 1'b1);
      check("ready_o", ready_o, 1'b0);
      check($sformatf("byte%0d", i), data_o, exp[i]);
      if (intrude && i == 2) begin
        valid_i = 1'b1;
        opcode_i = ~op;
        result_i = ~res;
        nbytes_i = 4'd3;
      end
      r = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : (($urandom_range(0, 1) == 1) || stall > 8);
      ready_i = r;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (r) begin
        i++;
        stall = 0;
      end else stall++;
    end
    check("end_ready", ready_o, 1'b1);
    check("end_valid", valid_o, 1'b0);
    check("end_busy", busy_o, 1'b0);
    check("end_data", data_o, 8'h00);
    ready_i = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] r64;
    repeat (3) @(negedge clk);
    check("rst_valid", valid_o, 1'b0);
    check("rst_ready", ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_data", data_o, 8'h00);
    rst = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    check("post_rst_valid", valid_o, 1'b0);
    check("post_rst_ready", ready_o, 1'b1);
    run_frame(8'h01, 64'h0000_0000_DEAD_BEEF, 4'd4, 0, 1'b0, -1);
    run_frame(8'h03, 64'h1122_3344_5566_7788, 4'd8, 1, 1'b0, -1);
    run_frame(8'h02, 64'h0000_0000_0000_0123, 4'd0, 2, 1'b0, -1);
    run_frame(8'h04, 64'hCAFE_F00D_1234_5678, 4'd15, 0, 1'b0, -1);
    run_frame(8'h05, 64'h0F1E_2D3C_4B5A_6978, 4'd5, 0, 1'b1, -1);
    run_frame(8'hFA, ~64'h0F1E_2D3C_4B5A_6978, 4'd3, 2, 1'b0, -1);
    run_frame(8'h06, 64'hA1B2_C3D4_E5F6_0718, 4'd6, 0, 1'b0, 6);
    run_frame(8'h07, 64'h9988_7766_5544_3322, 4'd2, 0, 1'b0, -1);
    for (int t = 0; t < 40; t++) begin
      r64 = {$urandom, $urandom};
      run_frame(8'($urandom), r64, 4'($urandom), int'($urandom_range(0, 2)), 1'b0, -1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
